// File: rtl/kyber_gs_bfu.sv
// ============================================================================
// kyber_gs_bfu -- Kyber (Q=3329) Gentleman-Sande inverse-NTT butterfly.
//
// Computes one butterfly per accepted input through a 3-stage pipeline:
//   u = (a + b) mod Q
//   v = ((a - b) mod Q) * zeta mod Q
// Neither output is halved; the division by 2 happens in a downstream stage.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   input butterfly presented
//   in_ready   out  input accepted this cycle (= global advance enable)
//   a_in       in   [DW-1:0] top coefficient, 0..Q-1
//   b_in       in   [DW-1:0] bottom coefficient, 0..Q-1
//   zeta_in    in   [DW-1:0] inverse-NTT twiddle, 0..Q-1
//   out_valid  out  u_out / v_out valid
//   out_ready  in   downstream accepts the output
//   u_out      out  [DW-1:0] (a+b) mod Q
//   v_out      out  [DW-1:0] ((a-b) mod Q)*zeta mod Q
//   bfly_cnt   out  [15:0] completed-butterfly count, wrapping
//                   (only present when KYBER_BFU_CNT_EN is defined)
//
// Build option
//   KYBER_BFU_CNT_EN : adds the bfly_cnt port and its counter. The datapath
//                      is identical with or without it.
// ============================================================================
`default_nettype none

module kyber_gs_bfu #(
    parameter int Q  = 3329,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    input  logic [DW-1:0] zeta_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] u_out,
    output logic [DW-1:0] v_out
`ifdef KYBER_BFU_CNT_EN
    ,
    output logic [15:0]   bfly_cnt
`endif
);

    localparam int STAGES = 3;
    localparam int PW     = 2 * DW;     // product width
    localparam int BK     = 3 * DW;     // Barrett shift
    // Barrett constant floor(2^BK / Q). With BK = 36 and p < 2^24 the
    // quotient estimate is at most one below the true quotient, so a single
    // conditional subtraction yields the exact residue.
    localparam longint unsigned BM = (64'd1 << BK) / 64'(Q);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [STAGES:1] r_vld_pipe;
    logic [DW-1:0]   r_s1, r_d1, r_z1;   // S1: sum, diff, zeta
    logic [PW-1:0]   r_p2;               // S2: diff*zeta
    logic [DW-1:0]   r_s2;
    logic [DW-1:0]   r_r3, r_s3;         // S3: reduced product, sum

    // Whole pipeline advances together whenever the output slot is free.
    logic w_en;
    assign w_en      = !r_vld_pipe[STAGES] | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld_pipe[STAGES];
    assign u_out     = r_s3;
    assign v_out     = r_r3;

    // ------------------------------------------------------------------
    // S1 combinational: modular add / sub, one conditional correction each
    // ------------------------------------------------------------------
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_s, w_d;

    always_comb begin
        w_sum = {1'b0, a_in} + {1'b0, b_in};
        if (w_sum >= (DW+1)'(Q))
            w_s = DW'(w_sum - (DW+1)'(Q));
        else
            w_s = w_sum[DW-1:0];

        if (a_in < b_in)
            w_d = DW'({1'b0, a_in} + (DW+1)'(Q) - {1'b0, b_in});
        else
            w_d = a_in - b_in;
    end

    // ------------------------------------------------------------------
    // S3 combinational: Barrett reduction of r_p2
    // ------------------------------------------------------------------
    logic [63:0]   w_bprod;
    logic [PW-1:0] w_quot;
    logic [PW-1:0] w_tq;
    logic [DW:0]   w_rem;    // p - t*Q lies in 0..2Q-1
    logic [DW-1:0] w_red;

    always_comb begin
        w_bprod = 64'(r_p2) * BM;
        w_quot  = PW'(w_bprod >> BK);
        w_tq    = w_quot * PW'(Q);
        w_rem   = (DW+1)'(r_p2 - w_tq);
        if (w_rem >= (DW+1)'(Q))
            w_red = DW'(w_rem - (DW+1)'(Q));
        else
            w_red = w_rem[DW-1:0];
    end

    // ------------------------------------------------------------------
    // Lockstep pipeline: bubbles travel with the data, nothing collapses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_s1       <= '0;
            r_d1       <= '0;
            r_z1       <= '0;
            r_p2       <= '0;
            r_s2       <= '0;
            r_r3       <= '0;
            r_s3       <= '0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
            r_s1       <= w_s;
            r_d1       <= w_d;
            r_z1       <= zeta_in;
            r_p2       <= PW'(r_d1) * PW'(r_z1);
            r_s2       <= r_s1;
            r_r3       <= w_red;
            r_s3       <= r_s2;
        end
    end

`ifdef KYBER_BFU_CNT_EN
    logic [15:0] r_bfly_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_bfly_cnt <= '0;
        else if (r_vld_pipe[STAGES] && out_ready)
            r_bfly_cnt <= r_bfly_cnt + 16'd1;   // wraps 65535 -> 0
    end

    assign bfly_cnt = r_bfly_cnt;
`endif

endmodule

`default_nettype wire
